// File: rtl/rom_16x8.sv
// -----------------------------------------------------------------------------
// rom_16x8 -- small constant lookup table on a shared tri-state read bus.
//
// Contents: word[i] = (i*i) mod 2**DW, i = 0 .. 2**AW-1. The table is built at
// elaboration. There is no write path, so the contents never change.
//
// Parameters
//   AW       address width; depth = 2**AW words (default 4)
//   DW       data width (default 8)
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous, active-high reset of the output register
//   ce       in   1   chip enable; 1 = perform a read this cycle
//   en       in   1   output enable; 1 = drive data, 0 = release bus (high-Z)
//   address  in   AW  word address; every value is a valid word
//   data     out  DW  read data, tri-state
//
// Configuration macro
//   ROM_ASYNC_READ_EN  defined   : combinational read, value = ce ? word : 0,
//                                  0-cycle latency, clk/rst unused
//                      undefined : registered read, 1-cycle latency (default)
// -----------------------------------------------------------------------------
module rom_16x8 #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          en,
    input  logic [AW-1:0] address,
    output logic [DW-1:0] data
);

    localparam int DEPTH = 2 ** AW;

    // Constant table. The cast to DW bits performs the mod 2**DW.
    logic [DW-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = DW'(i * i);
    end

    // An X/Z address yields X from the array index; it is deliberately not masked.
    logic [DW-1:0] rd_word;
    assign rd_word = rom[address];

`ifdef ROM_ASYNC_READ_EN

    logic [DW-1:0] value;
    assign value = ce ? rd_word : '0;

    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign data = en ? value : {DW{1'bz}};

`else

    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_d;

    // en is not involved here: a read with the bus released still loads dout_q.
    always_comb begin
        dout_d = dout_q;
        if (ce) dout_d = rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
    end

    // Output enable is purely combinational; no clock edge needed.
    assign data = en ? dout_q : {DW{1'bz}};

`endif

endmodule

// File: tb/tb_rom_16x8.sv
// -----------------------------------------------------------------------------
// tb_rom_16x8 -- self-checking bench for rom_16x8.
// Reads are issued with their expected word pushed to a scoreboard queue; the
// word is popped and compared once the DUT presents it. The bus is pulled up,
// so a released (high-Z) data bus reads as all-ones; no table word is FF.
// -----------------------------------------------------------------------------
module tb_rom_16x8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce  = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] address = '0;
    tri1  [7:0] data;

    rom_16x8 #(.AW(4), .DW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .en      (en),
        .address (address),
        .data    (data)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] BUS_Z = 8'hFF;

    logic [7:0] tbl [16] = '{8'h00, 8'h01, 8'h04, 8'h09, 8'h10, 8'h19, 8'h24, 8'h31,
                             8'h40, 8'h51, 8'h64, 8'h79, 8'h90, 8'hA9, 8'hC4, 8'hE1};

    int         passed = 0;
    int         total  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] held   = 8'h00;   // model of the output register

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle's read request and record what the register will hold.
    task automatic issue(input logic c, input logic [3:0] a);
        ce      = c;
        address = a;
        if (c) held = tbl[a];
        exp_q.push_back(held);
    endtask

    // Advance one edge, then compare the scoreboard head against the bus.
    task automatic step(input string tag);
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, data, en ? e : BUS_Z);
        end
    endtask

    initial begin
`ifdef ROM_ASYNC_READ_EN
        // Combinational build: no clock edge is awaited.
        ce = 1'b1; en = 1'b1; rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #5;
            chk($sformatf("async_rd%0d", a), data, tbl[a]);
        end
        ce = 1'b0;
        #5 chk("async_ce0", data, 8'h00);
        en = 1'b0;
        #5 chk("async_en0", data, BUS_Z);
        rst = 1'b0;
`else
        // 1. Reset
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b1; ce = 1'b1; address = 4'd5;
        #1 chk("rst_en1", data, 8'h00);
        en = 1'b0;
        #1 chk("rst_en0", data, BUS_Z);
        en = 1'b1;
        @(posedge clk); #1;
        chk("rst_held", data, 8'h00);
        rst = 1'b0; held = 8'h00;
        issue(1'b1, 4'd3);
        step("post_rst_rd3");

        // 2. Sweep with wrap
        for (int a = 0; a < 16; a++) begin
            issue(1'b1, 4'(a));
            step($sformatf("sweep%0d", a));
        end
        issue(1'b1, 4'(address + 4'd1));
        step("wrap");

        // 3. Output enable
        en = 1'b0;
        issue(1'b1, 4'd5);
        step("en0_rd5");
        issue(1'b1, 4'd7);
        step("en0_rd7");
        en = 1'b1;
        #2 chk("en_rise", data, 8'h31);

        // 4. Chip enable hold
        issue(1'b1, 4'd12);
        step("rd12");
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 4'd2);
            step($sformatf("ce0_hold%0d", k));
        end
        issue(1'b1, 4'd2);
        step("ce1_rd2");

        // 5. Async reset mid-stream
        for (int a = 0; a < 16; a++) begin
            issue(1'b1, 4'(a));
            step($sformatf("sweep2_%0d", a));
            if (a == 6) begin
                #2 rst = 1'b1;
                #1 chk("mid_rst", data, 8'h00);
                #1 rst = 1'b0;
                held = 8'h00;
                #1 chk("mid_rst_rel", data, 8'h00);
            end
        end
        ce = 1'b0;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety net in case the sequence never completes.
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected finish by 20000");
        $fatal(1, "timeout");
    end

endmodule
